dmem_sram_like_ctrl: RTL and testbench

- Memory-stage data-side request controller.
- Sits between the datapath M stage (aluoutM, writedata2M, sel, sizeM, memwriteM) and the data-side sram-like bus that feeds the AXI bridge.
- Turns each M-stage load/store into exactly one sram-like transaction and returns readdataM to the datapath.
- Raises stallreq_from_mem until the access completes, and discards in-flight responses when M is flushed by an exception.

---
 rtl/dmem_sram_like_ctrl.sv | 125 ++++++++++++
 tb/tb_dmem_sram_like_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sram_like_ctrl.sv
// Memory-stage data-side controller: turns one M-stage load/store into exactly
// one sram-like transaction, returns load data and stalls M until completion.
module dmem_sram_like_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_i,
  input  logic              mem_wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        size_i,
  input  logic              except_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stallreq_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DONE    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  state_t state_r;
  logic   valid_s;
  logic   kill_s;
  logic   stall_s;

  assign valid_s = mem_en_i & ~except_i & ~flush_i;
  assign kill_s  = flush_i | except_i;

  // Stall request; combinational so a fresh access holds M from its first cycle.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE:    stall_s = valid_s;
      ST_REQ:     stall_s = ~kill_s;
      ST_WAIT:    stall_s = ~kill_s;
      ST_DONE:    stall_s = 1'b0;
      ST_DISCARD: stall_s = valid_s;
      default:    stall_s = 1'b0;
    endcase
  end

  // Gated by reset so the pipeline sees no stall while the block is held in reset.
  assign stallreq_o = rst & stall_s;

  // Request FSM; bus fields are registered at launch and held while data_req is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= {ADDR_W{1'b0}};
      data_wdata <= {DATA_W{1'b0}};
      rdata_o    <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid_s) begin
            state_r    <= ST_REQ;
            data_req   <= 1'b1;
            data_wr    <= mem_wr_i;
            data_size  <= size_i;
            data_addr  <= addr_i;
            data_wdata <= wdata_i;
          end
        end
        ST_REQ: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state_r  <= kill_s ? ST_DISCARD : ST_WAIT;
          end else if (kill_s) begin
            data_req <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (data_data_ok) begin
            // A flush racing the response drops the data; nothing is outstanding.
            if (flush_i) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DONE;
              if (!data_wr) begin
                rdata_o <= data_rdata;
              end
            end
          end else if (flush_i) begin
            state_r <= ST_DISCARD;
          end
        end
        ST_DONE: begin
          if (flush_i || !stall_i) begin
            state_r <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (data_data_ok) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          data_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_like_ctrl.sv
// Self-checking bench for dmem_sram_like_ctrl: directed scenarios plus random
// accesses checked against a per-access model of latency, bus fields and load data.
module tb_dmem_sram_like_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en_i, mem_wr_i, except_i, flush_i, stall_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic        data_req, data_wr, data_addr_ok, data_data_ok, stallreq_o;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, rdata_o;

  int errors = 0;
  int checks = 0;
  int txn_cnt = 0;
  int obs_stall, obs_req, obs_field_bad, obs_done_stall, obs_done_unstable;
  logic [31:0] obs_rdata;
  logic [31:0] model_rdata;

  dmem_sram_like_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_en_i(mem_en_i), .mem_wr_i(mem_wr_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .size_i(size_i), .except_i(except_i), .flush_i(flush_i), .stall_i(stall_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .rdata_o(rdata_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && data_req && data_addr_ok) txn_cnt <= txn_cnt + 1;
  end

  assert property (@(posedge clk) disable iff (!rst) !(data_req && data_data_ok))
    else $error("FAIL bus_protocol: data_ok=%0b while data_req=%0b", data_data_ok, data_req);

  assert property (@(posedge clk) disable iff (!rst)
    (data_req && !data_addr_ok && !flush_i && !except_i) |=>
    (data_req && $stable(data_addr) && $stable(data_wdata) && $stable(data_size) && $stable(data_wr)))
    else $error("FAIL req_stable: request dropped or changed before addr_ok (req=%0b addr=%h)", data_req, data_addr);

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_en_i = 1'b0; mem_wr_i = 1'b0; except_i = 1'b0; flush_i = 1'b0;
    stall_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  // Drives one complete access from IDLE and records what the DUT showed.
  task automatic drive_access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int a_wait, input int d_wait, input int hold);
    int n, done0;
    logic [31:0] first_done;
    n = 4 + a_wait + d_wait + hold;
    done0 = 3 + a_wait + d_wait;
    first_done = 32'd0;
    obs_stall = 0; obs_req = 0; obs_field_bad = 0; obs_done_stall = 0; obs_done_unstable = 0;
    mem_en_i = 1'b1; mem_wr_i = wr; size_i = sz; addr_i = addr; wdata_i = wd;
    except_i = 1'b0; flush_i = 1'b0;
    for (int c = 0; c < n; c++) begin
      data_addr_ok = (c == 1 + a_wait);
      data_data_ok = (c == 2 + a_wait + d_wait);
      data_rdata   = data_data_ok ? rd : $urandom;
      stall_i      = (c < n - 1);
      @(negedge clk);
      if (c < done0) begin
        if (stallreq_o) obs_stall++;
      end else begin
        if (stallreq_o) obs_done_stall++;
        if (c == done0) first_done = rdata_o;
        else if (rdata_o !== first_done) obs_done_unstable++;
      end
      if (data_req) begin
        obs_req++;
        if ({data_wr, data_size, data_addr, data_wdata} !== {wr, sz, addr, wd}) obs_field_bad++;
      end
      next_cycle();
    end
    obs_rdata = first_done;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    addr_i = 32'd0; wdata_i = 32'd0; size_i = 2'd0; data_rdata = 32'd0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({data_req, data_wr, stallreq_o} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl: req/wr/stall=%b expected 000", {data_req, data_wr, stallreq_o}); end
    checks++; if (data_size !== 2'd0) begin errors++;
      $display("FAIL reset_size: got %0d expected 0", data_size); end
    checks++; if ({data_addr, data_wdata, rdata_o} !== 96'd0) begin errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected all 0", data_addr, data_wdata, rdata_o); end
    rst = 1'b1;
    model_rdata = 32'd0;
    next_cycle();
  endtask

  task automatic test_zero_wait_load();
    int t0;
    t0 = txn_cnt;
    drive_access(1'b0, 2'd2, 32'h1FC0_0100, $urandom, 32'hDEAD_BEEF, 0, 0, 0);
    model_rdata = 32'hDEAD_BEEF;
    checks++; if (obs_stall !== 3) begin errors++; $display("FAIL zw_stall_cycles: got %0d expected 3", obs_stall); end
    checks++; if (obs_req !== 1) begin errors++; $display("FAIL zw_req_cycles: got %0d expected 1", obs_req); end
    checks++; if (obs_field_bad !== 0) begin errors++; $display("FAIL zw_fields: %0d bad cycles expected 0", obs_field_bad); end
    checks++; if (obs_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_rdata: got %h expected deadbeef", obs_rdata); end
    checks++; if (obs_done_stall !== 0) begin errors++; $display("FAIL zw_done_stall: got %0d expected 0", obs_done_stall); end
    checks++; if (txn_cnt - t0 !== 1) begin errors++; $display("FAIL zw_txn: got %0d expected 1", txn_cnt - t0); end
  endtask

  task automatic test_byte_store();
    int t0;
    t0 = txn_cnt;
    drive_access(1'b1, 2'd0, 32'h8000_0003, 32'h7700_0000, $urandom, 3, 1, 0);
    checks++; if (obs_req !== 4) begin errors++; $display("FAIL st_req_cycles: got %0d expected 4", obs_req); end
    checks++; if (obs_field_bad !== 0) begin errors++; $display("FAIL st_fields: %0d bad cycles expected 0", obs_field_bad); end
    checks++; if (obs_stall !== 7) begin errors++; $display("FAIL st_stall_cycles: got %0d expected 7", obs_stall); end
    checks++; if (obs_rdata !== model_rdata) begin errors++; $display("FAIL st_rdata_kept: got %h expected %h", obs_rdata, model_rdata); end
    checks++; if (txn_cnt - t0 !== 1) begin errors++; $display("FAIL st_txn: got %0d expected 1", txn_cnt - t0); end
  endtask

  task automatic test_except();
    int t0;
    logic [31:0] rd;
    t0 = txn_cnt;
    rd = $urandom;
    mem_en_i = 1'b1; mem_wr_i = 1'b0; size_i = 2'd2; addr_i = 32'h0000_1001; except_i = 1'b1;
    @(negedge clk);
    checks++; if ({data_req, stallreq_o} !== 2'b00) begin errors++;
      $display("FAIL exc_first: req/stall=%b expected 00", {data_req, stallreq_o}); end
    next_cycle();
    flush_i = 1'b1;
    @(negedge clk);
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL exc_flush_req: got %b expected 0", data_req); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL exc_after_req: got %b expected 0", data_req); end
    next_cycle();
    drive_access(1'b0, 2'd2, 32'h0000_1100, $urandom, rd, 0, 0, 0);
    model_rdata = rd;
    checks++; if (obs_stall !== 3) begin errors++; $display("FAIL exc_next_stall: got %0d expected 3", obs_stall); end
    checks++; if (obs_rdata !== rd) begin errors++; $display("FAIL exc_next_rdata: got %h expected %h", obs_rdata, rd); end
    checks++; if (txn_cnt - t0 !== 1) begin errors++; $display("FAIL exc_txn: got %0d expected 1", txn_cnt - t0); end
  endtask

  task automatic test_flush_discard();
    int t0;
    logic [31:0] old, rd2;
    t0 = txn_cnt; old = model_rdata; rd2 = $urandom;
    mem_en_i = 1'b1; mem_wr_i = 1'b0; size_i = 2'd2; addr_i = 32'h0000_2000;
    next_cycle();
    data_addr_ok = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    checks++; if ({data_req, stallreq_o} !== 2'b10) begin errors++;
      $display("FAIL fd_req_flush: req/stall=%b expected 10", {data_req, stallreq_o}); end
    next_cycle();
    data_addr_ok = 1'b0; flush_i = 1'b0; addr_i = 32'h0000_3000;
    @(negedge clk);
    checks++; if ({data_req, stallreq_o} !== 2'b01) begin errors++;
      $display("FAIL fd_discard_wait: req/stall=%b expected 01", {data_req, stallreq_o}); end
    next_cycle();
    data_data_ok = 1'b1; data_rdata = $urandom;
    @(negedge clk);
    checks++; if ({data_req, stallreq_o} !== 2'b01) begin errors++;
      $display("FAIL fd_discard_ok: req/stall=%b expected 01", {data_req, stallreq_o}); end
    next_cycle();
    data_data_ok = 1'b0; mem_en_i = 1'b0;
    @(negedge clk);
    checks++; if (rdata_o !== old) begin errors++; $display("FAIL fd_rdata_dropped: got %h expected %h", rdata_o, old); end
    next_cycle();
    drive_access(1'b0, 2'd2, 32'h0000_3000, $urandom, rd2, 0, 0, 0);
    model_rdata = rd2;
    checks++; if (obs_stall !== 3) begin errors++; $display("FAIL fd_next_stall: got %0d expected 3", obs_stall); end
    checks++; if (obs_rdata !== rd2) begin errors++; $display("FAIL fd_next_rdata: got %h expected %h", obs_rdata, rd2); end
    checks++; if (txn_cnt - t0 !== 2) begin errors++; $display("FAIL fd_txn: got %0d expected 2", txn_cnt - t0); end
  endtask

  task automatic test_req_flush();
    int t0;
    logic [31:0] rd;
    t0 = txn_cnt; rd = $urandom;
    mem_en_i = 1'b1; mem_wr_i = 1'b1; size_i = 2'd1; addr_i = 32'h0000_4002; wdata_i = $urandom;
    next_cycle();
    flush_i = 1'b1;
    @(negedge clk);
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL rf_stall: got %b expected 0", stallreq_o); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rf_req_drop: got %b expected 0", data_req); end
    next_cycle();
    checks++; if (txn_cnt - t0 !== 0) begin errors++; $display("FAIL rf_txn: got %0d expected 0", txn_cnt - t0); end
    drive_access(1'b0, 2'd2, 32'h0000_4100, $urandom, rd, 1, 0, 0);
    model_rdata = rd;
    checks++; if (obs_stall !== 4) begin errors++; $display("FAIL rf_next_stall: got %0d expected 4", obs_stall); end
    checks++; if (obs_rdata !== rd) begin errors++; $display("FAIL rf_next_rdata: got %h expected %h", obs_rdata, rd); end
  endtask

  task automatic test_wait_flush();
    int t0;
    logic [31:0] old, rd;
    t0 = txn_cnt; old = model_rdata; rd = $urandom;
    mem_en_i = 1'b1; mem_wr_i = 1'b0; size_i = 2'd2; addr_i = 32'h0000_5000;
    next_cycle();
    data_addr_ok = 1'b1;
    next_cycle();
    data_addr_ok = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL wf_stall: got %b expected 0", stallreq_o); end
    next_cycle();
    flush_i = 1'b0; mem_en_i = 1'b0; data_data_ok = 1'b1; data_rdata = $urandom;
    @(negedge clk);
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL wf_discard_req: got %b expected 0", data_req); end
    next_cycle();
    data_data_ok = 1'b0; mem_en_i = 1'b1; addr_i = 32'h0000_5004;
    next_cycle();
    data_addr_ok = 1'b1;
    next_cycle();
    data_addr_ok = 1'b0; flush_i = 1'b1; data_data_ok = 1'b1; data_rdata = $urandom;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (rdata_o !== old) begin errors++; $display("FAIL wf_rdata_dropped: got %h expected %h", rdata_o, old); end
    next_cycle();
    drive_access(1'b0, 2'd2, 32'h0000_5008, $urandom, rd, 0, 2, 0);
    model_rdata = rd;
    checks++; if (obs_stall !== 5) begin errors++; $display("FAIL wf_next_stall: got %0d expected 5", obs_stall); end
    checks++; if (obs_rdata !== rd) begin errors++; $display("FAIL wf_next_rdata: got %h expected %h", obs_rdata, rd); end
    checks++; if (txn_cnt - t0 !== 3) begin errors++; $display("FAIL wf_txn: got %0d expected 3", txn_cnt - t0); end
  endtask

  task automatic test_stall_hold();
    int t0;
    logic [31:0] rd;
    t0 = txn_cnt; rd = $urandom | 32'd1;
    drive_access(1'b0, 2'd2, $urandom & 32'hFFFF_FFFC, $urandom, rd, 0, 0, 5);
    model_rdata = rd;
    checks++; if (obs_done_stall !== 0) begin errors++; $display("FAIL sh_done_stall: got %0d expected 0", obs_done_stall); end
    checks++; if (obs_done_unstable !== 0) begin errors++; $display("FAIL sh_rdata_hold: %0d changes expected 0", obs_done_unstable); end
    checks++; if (obs_rdata !== rd) begin errors++; $display("FAIL sh_rdata: got %h expected %h", obs_rdata, rd); end
    checks++; if (obs_req !== 1) begin errors++; $display("FAIL sh_req_cycles: got %0d expected 1", obs_req); end
    checks++; if (txn_cnt - t0 !== 1) begin errors++; $display("FAIL sh_txn: got %0d expected 1", txn_cnt - t0); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd;
    rd = $urandom;
    mem_en_i = 1'b1; mem_wr_i = 1'b0; size_i = 2'd2; addr_i = 32'h0000_6000;
    next_cycle();
    data_addr_ok = 1'b1;
    next_cycle();
    data_addr_ok = 1'b0; mem_en_i = 1'b0; rst = 1'b0;
    #1;
    checks++; if ({data_req, data_wr, stallreq_o, data_size} !== 5'd0) begin errors++;
      $display("FAIL rw_ctrl_zero: req/wr/stall/size=%b expected 00000", {data_req, data_wr, stallreq_o, data_size}); end
    checks++; if ({data_addr, data_wdata, rdata_o} !== 96'd0) begin errors++;
      $display("FAIL rw_data_zero: addr=%h wdata=%h rdata=%h expected all 0", data_addr, data_wdata, rdata_o); end
    model_rdata = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if ({data_req, stallreq_o} !== 2'b00) begin errors++;
      $display("FAIL rw_late_ok: req/stall=%b expected 00", {data_req, stallreq_o}); end
    next_cycle();
    data_data_ok = 1'b0;
    @(negedge clk);
    checks++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL rw_late_rdata: got %h expected 0", rdata_o); end
    next_cycle();
    drive_access(1'b0, 2'd2, 32'h0000_6100, $urandom, rd, 0, 0, 0);
    model_rdata = rd;
    checks++; if (obs_stall !== 3) begin errors++; $display("FAIL rw_next_stall: got %0d expected 3", obs_stall); end
    checks++; if (obs_rdata !== rd) begin errors++; $display("FAIL rw_next_rdata: got %h expected %h", obs_rdata, rd); end
  endtask

  task automatic test_random();
    int t0, a, d, h, gap;
    logic wr;
    logic [1:0] sz;
    logic [31:0] addr, wd, rd, exp_rd;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 2));
      addr = $urandom; wd = $urandom; rd = $urandom;
      a = $urandom_range(0, 3); d = $urandom_range(0, 3); h = $urandom_range(0, 3);
      gap = $urandom_range(0, 2);
      exp_rd = wr ? model_rdata : rd;
      t0 = txn_cnt;
      drive_access(wr, sz, addr, wd, rd, a, d, h);
      checks++; if (obs_stall !== 3 + a + d) begin errors++;
        $display("FAIL rnd%0d_stall: got %0d expected %0d", i, obs_stall, 3 + a + d); end
      checks++; if (obs_req !== a + 1) begin errors++;
        $display("FAIL rnd%0d_req: got %0d expected %0d", i, obs_req, a + 1); end
      checks++; if (obs_field_bad !== 0) begin errors++;
        $display("FAIL rnd%0d_fields: %0d bad cycles expected 0", i, obs_field_bad); end
      checks++; if (obs_rdata !== exp_rd) begin errors++;
        $display("FAIL rnd%0d_rdata: got %h expected %h", i, obs_rdata, exp_rd); end
      checks++; if (obs_done_stall + obs_done_unstable !== 0) begin errors++;
        $display("FAIL rnd%0d_done: stall=%0d changes=%0d expected 0/0", i, obs_done_stall, obs_done_unstable); end
      checks++; if (txn_cnt - t0 !== 1) begin errors++;
        $display("FAIL rnd%0d_txn: got %0d expected 1", i, txn_cnt - t0); end
      model_rdata = exp_rd;
      repeat (gap) next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_byte_store();
    test_except();
    test_flush_discard();
    test_req_flush();
    test_wait_flush();
    test_stall_hold();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
